// File: rtl/relobi_cut.sv
// -----------------------------------------------------------------------------
// relobi_cut -- one-cycle register slice for the reliable OBI (relOBI) bus.
//
// Sits directly downstream of the OBI-to-relOBI encoder to cut timing paths
// between a manager and the relOBI crossbar. The A and R channels are
// registered independently. Handshakes stay triplicated. Each channel's
// occupancy is kept as three flag copies that are majority-voted and
// rewritten from the voted value every cycle, so an upset copy self-heals.
//
// Ports:
//   clk_i      - clock
//   rst_ni     - asynchronous active-low reset
//   sbr_req_i  - relOBI request from upstream (encoder side)
//   sbr_rsp_o  - relOBI response to upstream
//   mgr_req_o  - relOBI request to downstream
//   mgr_rsp_i  - relOBI response from downstream
//   fault_o    - registered one-cycle pulse on any voter disagreement
//                (or, with scrubbing, any ECC error on a captured payload)
//
// Optional feature macro: RELOBI_CUT_SCRUB_EN
//   Defined   : addr/wdata/rdata and the grouped A/R other-field codewords are
//               Hsiao-decoded, corrected and re-encoded before the register.
//   Undefined : payloads are stored verbatim.
//
// Codeword layout used by the scrubber: data bits in the LSBs, check bits
// directly above them.
// -----------------------------------------------------------------------------
package obi_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
    logic        UseRReady;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    AddrWidth: 32, DataWidth: 32, IdWidth: 1, UseRReady: 1'b1
  };

  typedef logic a_optional_t;
  typedef logic r_optional_t;

  // 32-bit words carry 7 Hsiao check bits.
  typedef struct packed {
    logic [38:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [38:0] wdata;
    logic        aid;
    a_optional_t a_optional;
    logic [4:0]  other_ecc;   // protects {we, be, aid, a_optional}
  } relobi_a_chan_t;

  typedef struct packed {
    logic [38:0] rdata;
    logic        rid;
    logic        err;
    r_optional_t r_optional;
    logic [3:0]  other_ecc;   // protects {rid, err, r_optional}
  } relobi_r_chan_t;

  typedef struct packed {
    logic [2:0]     req;
    relobi_a_chan_t a;
    logic [2:0]     rready;
  } relobi_req_t;

  typedef struct packed {
    logic [2:0]     gnt;
    logic [2:0]     rvalid;
    relobi_r_chan_t r;
  } relobi_rsp_t;

endpackage

module relobi_cut #(
  parameter obi_pkg::obi_cfg_t Cfg = obi_pkg::ObiDefaultConfig,
  parameter type relobi_req_t = obi_pkg::relobi_req_t,
  parameter type relobi_rsp_t = obi_pkg::relobi_rsp_t,
  parameter type a_optional_t = obi_pkg::a_optional_t,
  parameter type r_optional_t = obi_pkg::r_optional_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  relobi_req_t sbr_req_i,
  output relobi_rsp_t sbr_rsp_o,
  output relobi_req_t mgr_req_o,
  input  relobi_rsp_t mgr_rsp_i,
  output logic        fault_o
);

  localparam logic UseRReady = Cfg.UseRReady;
  localparam int unsigned AW = $bits(sbr_req_i.a);
  localparam int unsigned RW = $bits(mgr_rsp_i.r);

  function automatic logic vote3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
  endfunction

  // High when the three copies do not all agree.
  function automatic logic split3(input logic [2:0] v);
    return (|v) & ~(&v);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]    a_full_q, a_full_d;
  logic [2:0]    r_full_q, r_full_d;
  logic [AW-1:0] a_data_q, a_data_d;
  logic [RW-1:0] r_data_q, r_data_d;
  logic          fault_q,  fault_d;

  logic          a_full, a_drain, a_ready, a_capture;
  logic          r_full, r_drain, r_ready, r_capture;
  logic [AW-1:0] a_in;
  logic [RW-1:0] r_in;
  logic          ecc_err;

  // ---------------------------------------------------------------------------
  // Payload path (optional scrubbing)
  // ---------------------------------------------------------------------------
`ifdef RELOBI_CUT_SCRUB_EN
  localparam int unsigned CwMax = 39;

  // j-th Hsiao column: odd weight >= 3, enumerated in ascending order.
  function automatic logic [7:0] hsiao_col(input int unsigned j, input int unsigned r);
    int unsigned n;
    logic [7:0]  v;
    hsiao_col = '0;
    n = 0;
    for (int x = 0; x < 256; x++) begin
      v = 8'(x);
      if (x < (1 << r) && $countones(v) >= 3 && $countones(v) % 2 == 1) begin
        if (n == j) hsiao_col = v;
        n++;
      end
    end
  endfunction

  // Decode, correct a single data-bit error and re-encode the check bits.
  function automatic logic [CwMax-1:0] hsiao_scrub(input logic [CwMax-1:0] cw,
                                                   input int unsigned k,
                                                   input int unsigned r,
                                                   output logic err);
    logic [7:0]       syn;
    logic [7:0]       chk;
    logic [CwMax-1:0] fixed;
    syn = '0;
    for (int j = 0; j < CwMax; j++)
      if (j < k && cw[j]) syn ^= hsiao_col(j, r);
    for (int i = 0; i < 8; i++)
      if (i < r) syn[i] ^= cw[k+i];
    fixed = cw;
    for (int j = 0; j < CwMax; j++)
      if (j < k && syn == hsiao_col(j, r)) fixed[j] = ~fixed[j];
    chk = '0;
    for (int j = 0; j < CwMax; j++)
      if (j < k && fixed[j]) chk ^= hsiao_col(j, r);
    for (int i = 0; i < 8; i++)
      if (i < r) fixed[k+i] = chk[i];
    err = |syn;
    return fixed;
  endfunction

  localparam int unsigned AddrCwW  = $bits(sbr_req_i.a.addr);
  localparam int unsigned DataCwW  = $bits(sbr_req_i.a.wdata);
  localparam int unsigned AOthK    = $bits(sbr_req_i.a.we) + $bits(sbr_req_i.a.be)
                                   + $bits(sbr_req_i.a.aid) + $bits(a_optional_t);
  localparam int unsigned AOthR    = $bits(sbr_req_i.a.other_ecc);
  localparam int unsigned ROthK    = $bits(mgr_rsp_i.r.rid) + $bits(mgr_rsp_i.r.err)
                                   + $bits(r_optional_t);
  localparam int unsigned ROthR    = $bits(mgr_rsp_i.r.other_ecc);

  relobi_req_t      a_scrub;
  relobi_rsp_t      r_scrub;
  logic [CwMax-1:0] cw_fix [5];
  logic [4:0]       cw_err;

  always_comb begin
    a_scrub = sbr_req_i;
    r_scrub = mgr_rsp_i;
    cw_fix[0] = hsiao_scrub(CwMax'(a_scrub.a.addr), Cfg.AddrWidth,
                            AddrCwW - Cfg.AddrWidth, cw_err[0]);
    cw_fix[1] = hsiao_scrub(CwMax'(a_scrub.a.wdata), Cfg.DataWidth,
                            DataCwW - Cfg.DataWidth, cw_err[1]);
    cw_fix[2] = hsiao_scrub(CwMax'({a_scrub.a.other_ecc, a_scrub.a.we, a_scrub.a.be,
                                    a_scrub.a.aid, a_scrub.a.a_optional}),
                            AOthK, AOthR, cw_err[2]);
    cw_fix[3] = hsiao_scrub(CwMax'(r_scrub.r.rdata), Cfg.DataWidth,
                            DataCwW - Cfg.DataWidth, cw_err[3]);
    cw_fix[4] = hsiao_scrub(CwMax'({r_scrub.r.other_ecc, r_scrub.r.rid, r_scrub.r.err,
                                    r_scrub.r.r_optional}),
                            ROthK, ROthR, cw_err[4]);
    a_scrub.a.addr  = cw_fix[0][AddrCwW-1:0];
    a_scrub.a.wdata = cw_fix[1][DataCwW-1:0];
    {a_scrub.a.other_ecc, a_scrub.a.we, a_scrub.a.be, a_scrub.a.aid,
     a_scrub.a.a_optional} = cw_fix[2][AOthK+AOthR-1:0];
    r_scrub.r.rdata = cw_fix[3][DataCwW-1:0];
    {r_scrub.r.other_ecc, r_scrub.r.rid, r_scrub.r.err,
     r_scrub.r.r_optional} = cw_fix[4][ROthK+ROthR-1:0];
    a_in = a_scrub.a;
    r_in = r_scrub.r;
    // Idle buses may carry arbitrary payload bits; only captured words count.
    ecc_err = (a_capture & (|cw_err[2:0])) | (r_capture & (|cw_err[4:3]));
  end
`else
  assign a_in    = sbr_req_i.a;
  assign r_in    = mgr_rsp_i.r;
  assign ecc_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // A channel
  // ---------------------------------------------------------------------------
  assign a_full    = vote3(a_full_q);
  assign a_drain   = a_full & vote3(mgr_rsp_i.gnt);
  assign a_ready   = ~a_full | a_drain;
  assign a_capture = vote3(sbr_req_i.req) & a_ready;

  // ---------------------------------------------------------------------------
  // R channel. Without rready the slice always drains, which degenerates to a
  // plain pipeline register that follows the voted rvalid.
  // ---------------------------------------------------------------------------
  assign r_full    = vote3(r_full_q);
  assign r_drain   = r_full & (UseRReady ? vote3(sbr_req_i.rready) : 1'b1);
  assign r_ready   = ~r_full | r_drain;
  assign r_capture = vote3(mgr_rsp_i.rvalid) & r_ready;

  // ---------------------------------------------------------------------------
  // Next state: all flag copies rewritten from the voted result every cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    a_full_d = {3{a_capture | (a_full & ~a_drain)}};
    r_full_d = {3{r_capture | (r_full & ~r_drain)}};
    a_data_d = a_capture ? a_in : a_data_q;
    r_data_d = r_capture ? r_in : r_data_q;
    fault_d  = split3(sbr_req_i.req) | split3(mgr_rsp_i.gnt)
             | split3(mgr_rsp_i.rvalid)
             | (UseRReady & split3(sbr_req_i.rready))
             | split3(a_full_q) | split3(r_full_q)
             | ecc_err;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_full_q <= '0;
      r_full_q <= '0;
      a_data_q <= '0;
      r_data_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      a_full_q <= a_full_d;
      r_full_q <= r_full_d;
      a_data_q <= a_data_d;
      r_data_q <= r_data_d;
      fault_q  <= fault_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    sbr_rsp_o        = '0;
    sbr_rsp_o.gnt    = {3{a_ready}};
    sbr_rsp_o.rvalid = {3{r_full}};
    sbr_rsp_o.r      = r_data_q;
    mgr_req_o        = '0;
    mgr_req_o.req    = {3{a_full}};
    mgr_req_o.a      = a_data_q;
    mgr_req_o.rready = {3{r_ready}};
  end

  assign fault_o = fault_q;

endmodule

// File: tb/tb_relobi_cut.sv
// -----------------------------------------------------------------------------
// tb_relobi_cut -- directed self-checking bench for relobi_cut.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled a
// further 1 time unit later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_relobi_cut;

  logic                clk = 1'b0;
  logic                rst_n;
  obi_pkg::relobi_req_t sbr_req;
  obi_pkg::relobi_rsp_t sbr_rsp;
  obi_pkg::relobi_req_t mgr_req;
  obi_pkg::relobi_rsp_t mgr_rsp;
  logic                fault;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  relobi_cut #(
    .Cfg          (obi_pkg::ObiDefaultConfig),
    .relobi_req_t (obi_pkg::relobi_req_t),
    .relobi_rsp_t (obi_pkg::relobi_rsp_t),
    .a_optional_t (obi_pkg::a_optional_t),
    .r_optional_t (obi_pkg::r_optional_t)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .sbr_req_i (sbr_req),
    .sbr_rsp_o (sbr_rsp),
    .mgr_req_o (mgr_req),
    .mgr_rsp_i (mgr_rsp),
    .fault_o   (fault)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic obi_pkg::relobi_a_chan_t mk_a(input logic [31:0] addr,
                                                   input logic [31:0] wdata);
    obi_pkg::relobi_a_chan_t a;
    a       = '0;
    a.addr  = {7'h15, addr};
    a.we    = 1'b1;
    a.be    = 4'hf;
    a.wdata = {7'h2a, wdata};
    return a;
  endfunction

  function automatic obi_pkg::relobi_r_chan_t mk_r(input logic [31:0] rdata);
    obi_pkg::relobi_r_chan_t r;
    r       = '0;
    r.rdata = {7'h33, rdata};
    r.rid   = 1'b1;
    return r;
  endfunction

  obi_pkg::relobi_a_chan_t pay [4];
  obi_pkg::relobi_a_chan_t a1, a2, a3, a4;
  obi_pkg::relobi_r_chan_t r1, r2;

  // Back-to-back-with-stall expectations, indexed by cycle.
  logic [2:0] exp_gnt [8] = '{3'b111, 3'b000, 3'b000, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
  logic [2:0] exp_req [8] = '{3'b000, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b000};
  int         exp_idx [8] = '{0, 0, 0, 0, 1, 2, 3, 0};

  initial begin
    int  idx;
    logic hs;

    rst_n   = 1'b0;
    sbr_req = '0;
    mgr_rsp = '0;
    a1 = mk_a(32'h0000_1000, 32'hDEAD_BEEF);
    a2 = mk_a(32'h0000_3000, 32'h1234_5678);
    a3 = mk_a(32'h0000_4000, 32'hCAFE_F00D);
    a4 = mk_a(32'h0000_5000, 32'h0BAD_C0DE);
    r1 = mk_r(32'hA5A5_0001);
    r2 = mk_r(32'h5A5A_0002);
    for (int i = 0; i < 4; i++) pay[i] = mk_a(32'h2000 + 32'(4 * i), 32'h1111_0000 + 32'(i));

    // ---------------- reset state ----------------
    #2;
    check_eq("rst_mgr_req",   128'(mgr_req.req),    128'(3'b000));
    check_eq("rst_sbr_gnt",   128'(sbr_rsp.gnt),    128'(3'b111));
    check_eq("rst_sbr_rvld",  128'(sbr_rsp.rvalid), 128'(3'b000));
    check_eq("rst_mgr_rrdy",  128'(mgr_req.rready), 128'(3'b111));
    check_eq("rst_mgr_a",     128'(mgr_req.a),      128'(0));
    check_eq("rst_fault",     128'(fault),          128'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ---------------- single write ----------------
    mgr_rsp.gnt = 3'b111;
    sbr_req.req = 3'b111;
    sbr_req.a   = a1;
    #1;
    check_eq("wr_gnt_idle", 128'(sbr_rsp.gnt), 128'(3'b111));
    step();
    sbr_req.req = 3'b000;
    #1;
    check_eq("wr_mgr_req",  128'(mgr_req.req), 128'(3'b111));
    check_eq("wr_mgr_a",    128'(mgr_req.a),   128'(a1));
    check_eq("wr_gnt_full", 128'(sbr_rsp.gnt), 128'(3'b111));
    step();
    check_eq("wr_drained",  128'(mgr_req.req), 128'(3'b000));

    // ---------------- back-to-back with 3-cycle stall ----------------
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      sbr_req.req = (idx < 4) ? 3'b111 : 3'b000;
      sbr_req.a   = (idx < 4) ? pay[idx] : '0;
      mgr_rsp.gnt = (c < 3) ? 3'b000 : 3'b111;
      #1;
      check_eq($sformatf("b2b_gnt_c%0d", c), 128'(sbr_rsp.gnt), 128'(exp_gnt[c]));
      check_eq($sformatf("b2b_req_c%0d", c), 128'(mgr_req.req), 128'(exp_req[c]));
      if (exp_req[c] == 3'b111)
        check_eq($sformatf("b2b_a_c%0d", c), 128'(mgr_req.a), 128'(pay[exp_idx[c]]));
      hs = sbr_req.req[0] & sbr_rsp.gnt[0];
      step();
      if (hs) idx++;
    end
    check_eq("b2b_all_accepted", 128'(idx), 128'(4));
    sbr_req = '0;

    // ---------------- single-bit upset on downstream gnt ----------------
    mgr_rsp.gnt = 3'b000;
    sbr_req.req = 3'b111;
    sbr_req.a   = a2;
    step();
    sbr_req.req = 3'b000;
    mgr_rsp.gnt = 3'b110;
    #1;
    check_eq("upset_gnt_full",  128'(mgr_req.req), 128'(3'b111));
    check_eq("upset_gnt_drain", 128'(sbr_rsp.gnt), 128'(3'b111));
    step();
    mgr_rsp.gnt = 3'b111;
    check_eq("upset_gnt_req",   128'(mgr_req.req), 128'(3'b000));
    check_eq("upset_gnt_fault", 128'(fault),       128'(1));
    step();
    check_eq("upset_gnt_fault_end", 128'(fault),   128'(0));

    // ---------------- single-bit upset on a flag copy ----------------
    force dut.a_full_q = 3'b010;
    #1;
    check_eq("upset_flag_req",   128'(mgr_req.req), 128'(3'b000));
    check_eq("upset_flag_gnt",   128'(sbr_rsp.gnt), 128'(3'b111));
    step();
    check_eq("upset_flag_fault", 128'(fault),       128'(1));
    release dut.a_full_q;
    step();
    step();
    check_eq("upset_flag_repair", 128'(dut.a_full_q), 128'(3'b000));
    check_eq("upset_flag_quiet",  128'(fault),        128'(0));

    // ---------------- async reset mid-stall ----------------
    mgr_rsp.gnt = 3'b000;
    sbr_req.req = 3'b111;
    sbr_req.a   = a3;
    step();
    sbr_req.req = 3'b000;
    #1;
    check_eq("arst_full", 128'(mgr_req.req), 128'(3'b111));
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_req",  128'(mgr_req.req), 128'(3'b000));
    check_eq("arst_gnt",  128'(sbr_rsp.gnt), 128'(3'b111));
    check_eq("arst_a",    128'(mgr_req.a),   128'(0));
    #2;
    rst_n = 1'b1;
    step();
    mgr_rsp.gnt = 3'b111;
    sbr_req.req = 3'b111;
    sbr_req.a   = a4;
    step();
    sbr_req.req = 3'b000;
    #1;
    check_eq("arst_after_req", 128'(mgr_req.req), 128'(3'b111));
    check_eq("arst_after_a",   128'(mgr_req.a),   128'(a4));
    step();

    // ---------------- R channel with backpressure ----------------
    mgr_rsp.rvalid = 3'b111;
    mgr_rsp.r      = r1;
    sbr_req.rready = 3'b111;
    #1;
    check_eq("r_rready_idle", 128'(mgr_req.rready), 128'(3'b111));
    step();
    check_eq("r_rvalid", 128'(sbr_rsp.rvalid), 128'(3'b111));
    check_eq("r_data1",  128'(sbr_rsp.r),      128'(r1));
    mgr_rsp.r      = r2;
    sbr_req.rready = 3'b000;
    #1;
    check_eq("r_stall_rready", 128'(mgr_req.rready), 128'(3'b000));
    step();
    check_eq("r_stall_hold",   128'(sbr_rsp.r),      128'(r1));
    sbr_req.rready = 3'b111;
    step();
    mgr_rsp.rvalid = 3'b000;
    check_eq("r_data2",  128'(sbr_rsp.r),      128'(r2));
    step();
    check_eq("r_empty",  128'(sbr_rsp.rvalid), 128'(3'b000));

`ifdef RELOBI_CUT_SCRUB_EN
    // ---------------- scrub: single-bit rdata error ----------------
    mgr_rsp.rvalid = 3'b111;
    mgr_rsp.r      = '0;
    mgr_rsp.r.rdata[5] = 1'b1;
    step();
    mgr_rsp.rvalid = 3'b000;
    check_eq("scrub_rdata", 128'(sbr_rsp.r), 128'(0));
    check_eq("scrub_fault", 128'(fault),     128'(1));
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
